// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-access DRAM controller.
// Define ARB_PORT0_PRIORITY_EN to give port 0 fixed priority on ties.
`timescale 1ns/1ps
module dram_port_arbiter #(
   parameter int ADDR_W  = 27,
   parameter int DATA_W  = 64,
   parameter int TMO_CYC = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic              ctl_read,
   output logic              ctl_write,
   output logic [ADDR_W-1:0] ctl_address,
   output logic [DATA_W-1:0] ctl_write_data,
   input  logic [DATA_W-1:0] ctl_read_data,
   input  logic              ctl_busy
);

   localparam int CNT_W = $clog2(TMO_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CAPTURE,
      S_RESPOND
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic              r_err;
   logic              r_win;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_grant;
   logic              w_pick;
   logic              w_tmo;

`ifdef ARB_PORT0_PRIORITY_EN
   assign w_pick = ~req0_valid;
`else
   logic r_last;

   // On a tie the port not served last wins
   assign w_pick = (req0_valid & req1_valid) ? ~r_last : ~req0_valid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last <= 1'b1;
      end else if (w_grant) begin
         r_last <= w_pick;
      end
   end
`endif

   // Reset gates the grant so ready stays low while held in reset
   assign w_grant = rst_ni & (r_state == S_IDLE) & ~ctl_busy
                  & (req0_valid | req1_valid);
   assign w_tmo   = (r_cnt == CNT_W'(TMO_CYC));

   assign ctl_address    = r_addr;
   assign ctl_write_data = r_wdata;
   assign rsp0_rdata     = r_rdata0;
   assign rsp1_rdata     = r_rdata1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_next = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (ctl_busy) w_next = S_WAIT_DONE;
            else if (w_tmo) w_next = S_RESPOND;
         end
         S_WAIT_DONE: begin
            if (!ctl_busy) w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_next = S_RESPOND;
         end
         S_RESPOND: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      ctl_read   = 1'b0;
      ctl_write  = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp0_err   = 1'b0;
      rsp1_err   = 1'b0;
      req0_ready = w_grant & ~w_pick;
      req1_ready = w_grant & w_pick;
      if (r_state == S_ISSUE) begin
         ctl_read  = ~r_we;
         ctl_write = r_we;
      end
      if (r_state == S_RESPOND) begin
         rsp0_valid = ~r_win;
         rsp1_valid = r_win;
         rsp0_err   = ~r_win & r_err;
         rsp1_err   = r_win & r_err;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_win    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_grant) begin
            r_win   <= w_pick;
            r_err   <= 1'b0;
            r_we    <= w_pick ? req1_we : req0_we;
            r_addr  <= w_pick ? req1_addr : req0_addr;
            r_wdata <= w_pick ? req1_wdata : req0_wdata;
         end
         // Saturating count of idle cycles while waiting for busy
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT_BUSY && !w_tmo) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == S_WAIT_BUSY && !ctl_busy && w_tmo) begin
            r_err <= 1'b1;
         end
         if (r_state == S_CAPTURE && !r_we) begin
            if (r_win) r_rdata1 <= ctl_read_data;
            else r_rdata0 <= ctl_read_data;
         end
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed scoreboard bench for dram_port_arbiter with a simple
// controller model that raises busy the cycle after each command.
`timescale 1ns/1ps
module tb_dram_port_arbiter;

   localparam int AW  = 27;
   localparam int DW  = 64;
   localparam int TMO = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req0_valid = 1'b0;
   logic          req0_we = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req1_valid = 1'b0;
   logic          req1_we = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic [DW-1:0] ctl_read_data = '0;
   logic          req0_ready, req1_ready;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_err, rsp1_err;
   logic [DW-1:0] rsp0_rdata, rsp1_rdata;
   logic          ctl_read, ctl_write;
   logic [AW-1:0] ctl_address;
   logic [DW-1:0] ctl_write_data;
   logic          ctl_busy;

   logic init_busy = 1'b1;
   logic model_busy = 1'b0;
   bit   no_busy = 1'b0;
   int   L = 20;
   int   mcnt = 0;

   assign ctl_busy = init_busy | model_busy;

   dram_port_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TMO_CYC(TMO)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req0_valid    (req0_valid),
      .req0_we       (req0_we),
      .req0_addr     (req0_addr),
      .req0_wdata    (req0_wdata),
      .req0_ready    (req0_ready),
      .rsp0_valid    (rsp0_valid),
      .rsp0_rdata    (rsp0_rdata),
      .rsp0_err      (rsp0_err),
      .req1_valid    (req1_valid),
      .req1_we       (req1_we),
      .req1_addr     (req1_addr),
      .req1_wdata    (req1_wdata),
      .req1_ready    (req1_ready),
      .rsp1_valid    (rsp1_valid),
      .rsp1_rdata    (rsp1_rdata),
      .rsp1_err      (rsp1_err),
      .ctl_read      (ctl_read),
      .ctl_write     (ctl_write),
      .ctl_address   (ctl_address),
      .ctl_write_data(ctl_write_data),
      .ctl_read_data (ctl_read_data),
      .ctl_busy      (ctl_busy)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int            port;
      bit            err;
      logic [DW-1:0] rdata;
      int            lat;
   } exp_t;

   exp_t          sb[$];
   exp_t          e_cur;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            g_cyc = 0;
   int            issue_cyc = 0;
   int            last_rsp_cyc = 0;
   int            wr_pulses = 0;
   logic [AW-1:0] cap_addr = '0;
   logic [DW-1:0] cap_data = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Controller model: busy high for L cycles starting the cycle after the command
   always @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcnt = 0;
         model_busy = 1'b0;
      end else begin
         if ((ctl_read || ctl_write) && !no_busy) mcnt = L + 1;
         else if (mcnt > 0) mcnt = mcnt - 1;
         model_busy = (mcnt != 0) && (mcnt <= L);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (req0_ready || req1_ready) g_cyc = cyc;
         if (ctl_read || ctl_write) begin
            chk("ctl_excl", 64'(ctl_read & ctl_write), 64'd0);
            issue_cyc = cyc;
            if (ctl_write) begin
               wr_pulses++;
               cap_addr = ctl_address;
               cap_data = ctl_write_data;
            end
         end
         if (rsp0_valid || rsp1_valid) begin
            last_rsp_cyc = cyc;
            chk("rsp_both", 64'(rsp0_valid & rsp1_valid), 64'd0);
            n_cmp++;
            assert (sb.size() > 0) else begin
               n_bad++;
               $error("FAIL unexp_rsp: got rsp want none");
            end
            if (sb.size() > 0) begin
               e_cur = sb.pop_front();
               chk("rsp_port", 64'(rsp1_valid), 64'(e_cur.port));
               chk("rsp_err", 64'(rsp1_valid ? rsp1_err : rsp0_err),
                   64'(e_cur.err));
               chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata,
                   e_cur.rdata);
               chk("rsp_lat", 64'(cyc - g_cyc), 64'(e_cur.lat));
               chk("rsp_issue_lat", 64'(cyc - issue_cyc),
                   64'(e_cur.lat - 1));
            end
         end
      end
   end

   task automatic push(input int p, input bit err,
                       input logic [DW-1:0] rd, input int lat);
      exp_t e;
      e.port  = p;
      e.err   = err;
      e.rdata = rd;
      e.lat   = lat;
      sb.push_back(e);
   endtask

   task automatic send(input int p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      bit ok = 1'b0;
      if (p == 0) begin
         req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
      end
      for (int k = 0; k < 300; k++) begin
         @(negedge clk_i);
         if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      assert (ok) else begin
         n_bad++;
         $error("FAIL grant_p%0d: got no ready want ready", p);
      end
      @(posedge clk_i);
      #1;
      if (p == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int k = 0;
      while (sb.size() != 0 && k < 600) begin
         @(negedge clk_i);
         k++;
      end
      chk("rsp_drain", 64'(sb.size()), 64'd0);
      sb.delete();
      @(posedge clk_i);
      #1;
   endtask

   localparam logic [DW-1:0] R0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [DW-1:0] R1 = 64'h1122_3344_5566_7788;
   localparam logic [DW-1:0] R2 = 64'hCAFE_F00D_DEAD_BEEF;
   localparam logic [DW-1:0] R3 = 64'h0BAD_C0DE_1357_9BDF;
   localparam logic [DW-1:0] R4 = 64'h2468_ACE0_FDB9_7531;
   localparam logic [DW-1:0] WD = 64'hA5A5_5A5A_0F0F_F0F0;

   initial begin
      bit early;
      int g;
      int wb;
      // Reset with a pending request and an idle controller
      init_busy = 1'b0;
      req0_valid = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ready0", 64'(req0_ready), 64'd0);
      chk("rst_ready1", 64'(req1_ready), 64'd0);
      chk("rst_rsp0", 64'(rsp0_valid), 64'd0);
      chk("rst_rsp1", 64'(rsp1_valid), 64'd0);
      chk("rst_err0", 64'(rsp0_err), 64'd0);
      chk("rst_err1", 64'(rsp1_err), 64'd0);
      chk("rst_rd", 64'(ctl_read), 64'd0);
      chk("rst_wr", 64'(ctl_write), 64'd0);
      chk("rst_addr", 64'(ctl_address), 64'd0);
      chk("rst_wdata", ctl_write_data, 64'd0);
      chk("rst_rdata0", rsp0_rdata, 64'd0);
      chk("rst_rdata1", rsp1_rdata, 64'd0);

      // Controller init: no grant while busy
      init_busy = 1'b1;
      req0_we = 1'b0;
      req0_addr = 27'h100;
      ctl_read_data = R0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      early = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_i);
         if (req0_ready) early = 1'b1;
      end
      chk("ready_while_init", 64'(early), 64'd0);
      @(posedge clk_i);
      #1;
      init_busy = 1'b0;
      push(0, 1'b0, R0, 4 + L);
      send(0, 1'b0, 27'h100, 64'd0);
      wait_rsp();

      // Port 0 write, rdata must hold
      ctl_read_data = 64'hFFFF_FFFF_FFFF_FFFF;
      wb = wr_pulses;
      push(0, 1'b0, R0, 24);
      send(0, 1'b1, 27'h0001234, WD);
      wait_rsp();
      chk("wr_pulses", 64'(wr_pulses - wb), 64'd1);
      chk("wr_addr", 64'(cap_addr), 64'h0001234);
      chk("wr_data", cap_data, WD);

      // Port 1 read
      ctl_read_data = R1;
      push(1, 1'b0, R1, 24);
      send(1, 1'b0, 27'h2000, 64'd0);
      wait_rsp();

      // Both ports continuously requesting
      ctl_read_data = R2;
`ifdef ARB_PORT0_PRIORITY_EN
      push(0, 1'b0, R2, 24); push(0, 1'b0, R2, 24);
      push(0, 1'b0, R2, 24); push(0, 1'b0, R2, 24);
`else
      push(0, 1'b0, R2, 24); push(1, 1'b0, R2, 24);
      push(0, 1'b0, R2, 24); push(1, 1'b0, R2, 24);
`endif
      req0_we = 1'b0; req0_addr = 27'h3000;
      req1_we = 1'b0; req1_addr = 27'h3100;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      g = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk_i);
         if (req0_ready || req1_ready) begin
            g++;
            if (g >= 2) chk("regrant_gap", 64'(cyc - last_rsp_cyc), 64'd1);
            if (g == 4) break;
         end
      end
      @(posedge clk_i);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("tie_grants", 64'(g), 64'd4);
      wait_rsp();

      // Controller never goes busy: timeout, then normal service
      no_busy = 1'b1;
      push(0, 1'b1, R2, TMO + 3);
      send(0, 1'b0, 27'h300, 64'd0);
      wait_rsp();
      no_busy = 1'b0;
      ctl_read_data = R3;
      push(0, 1'b0, R3, 24);
      send(0, 1'b0, 27'h304, 64'd0);
      wait_rsp();

      // Reset in the middle of WAIT_DONE
      send(1, 1'b0, 27'h400, 64'h5555_0000_5555_0000);
      repeat (5) @(posedge clk_i);
      #1;
      init_busy = 1'b1;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_rd", 64'(ctl_read), 64'd0);
      chk("mid_rst_wr", 64'(ctl_write), 64'd0);
      chk("mid_rst_addr", 64'(ctl_address), 64'd0);
      chk("mid_rst_wdata", ctl_write_data, 64'd0);
      chk("mid_rst_rdata0", rsp0_rdata, 64'd0);
      chk("mid_rst_rdata1", rsp1_rdata, 64'd0);
      chk("mid_rst_rsp1", 64'(rsp1_valid), 64'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      req1_valid = 1'b1;
      req1_addr = 27'h404;
      early = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk_i);
         if (req1_ready || req0_ready) early = 1'b1;
      end
      chk("post_rst_no_grant", 64'(early), 64'd0);
      @(posedge clk_i);
      #1;
      init_busy = 1'b0;
      ctl_read_data = R4;
      push(1, 1'b0, R4, 24);
      send(1, 1'b0, 27'h404, 64'd0);
      wait_rsp();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
